datapath_multi_channel: RTL and testbench

DATAPATH_MULTI_CHANNEL -- requirements
Module: datapath_multi_channel

---
 rtl/datapath_pkg.sv | 13 +
 rtl/datapath_channel.sv | 50 +++++
 rtl/datapath_multi_channel.sv | 50 +++++
 tb/tb_datapath_multi_channel.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// datapath_pkg: default parameters and signed saturation shared by the multi-channel datapath
package datapath_pkg;
  localparam int N_CHANNELS_DEF = 4;
  localparam int W_IN_DEF = 9;
  localparam int N_BITS_ACC_EXT_DEF = 3;
  localparam int DECIM_DEF = 8;
  function automatic logic signed [31:0] sat_s(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    return v > hi ? hi : (v < lo ? lo : v);
  endfunction
endpackage

// File: rtl/datapath_channel.sv
// datapath_channel: one channel of difference, decimating accumulator and sticky saturation
module datapath_channel
  import datapath_pkg::*;
#(
  parameter int W_IN = W_IN_DEF,
  parameter int N_BITS_ACC_EXT = N_BITS_ACC_EXT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   emit,
  input  logic                   diff_en,
  input  logic                   clear_sat,
  input  logic signed [W_IN-1:0] counter_p,
  input  logic signed [W_IN-1:0] counter_n,
  output logic signed [W_IN-1:0] channel_output,
  output logic                   sat_flag
);
  localparam int W_ACC = W_IN + N_BITS_ACC_EXT;
  logic signed [W_IN:0] d_raw, diff_raw;
  logic signed [W_IN-1:0] d, diff, out_value, out_delayed;
  logic signed [W_ACC-1:0] acc;
  logic d_sat, diff_sat;
  always_comb begin
    d_raw = {counter_p[W_IN-1], counter_p} - {counter_n[W_IN-1], counter_n};
    d = W_IN'(sat_s(32'(d_raw), W_IN));
    d_sat = {d[W_IN-1], d} != d_raw;
    diff_raw = {out_value[W_IN-1], out_value} - {out_delayed[W_IN-1], out_delayed};
    diff = W_IN'(sat_s(32'(diff_raw), W_IN));
    diff_sat = {diff[W_IN-1], diff} != diff_raw;
  end
  // acc tracks the running error between input and decimated output; it wraps by design
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      out_value <= '0;
      out_delayed <= '0;
      channel_output <= '0;
      sat_flag <= 1'b0;
    end else begin
      acc <= acc + W_ACC'(d) - W_ACC'(out_value);
      if (tick) begin
        out_value <= acc[W_ACC-1:N_BITS_ACC_EXT];
        out_delayed <= out_value;
      end
      if (emit) channel_output <= diff_en ? diff : out_value;
      sat_flag <= d_sat | (emit & diff_en & diff_sat) | (sat_flag & ~clear_sat);
    end
  end
endmodule

// File: rtl/datapath_multi_channel.sv
// datapath_multi_channel: shared decimation timing driving N independent channel datapaths
module datapath_multi_channel
  import datapath_pkg::*;
#(
  parameter int N_CHANNELS = N_CHANNELS_DEF,
  parameter int W_IN = W_IN_DEF,
  parameter int N_BITS_ACC_EXT = N_BITS_ACC_EXT_DEF,
  parameter int DECIM = DECIM_DEF
) (
  input  logic                         CLK_24M,
  input  logic                         reset,
  input  logic [N_CHANNELS*W_IN-1:0]   counter_p,
  input  logic [N_CHANNELS*W_IN-1:0]   counter_n,
  input  logic                         diff_en,
  input  logic                         clear_sat,
  output logic [N_CHANNELS*W_IN-1:0]   channel_output,
  output logic                         out_valid,
  output logic [N_CHANNELS-1:0]        sat_flag
);
  localparam int W_CNT = $clog2(DECIM);
  logic [W_CNT-1:0] cnt;
  logic tick, tick_q;
  assign tick = cnt == W_CNT'(DECIM - 1);
  // tick_q marks the edge after a tick, so output never fires on the first edge after reset
  always_ff @(posedge CLK_24M) begin
    if (reset) begin
      cnt <= '0;
      tick_q <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + W_CNT'(1);
      tick_q <= tick;
      out_valid <= tick_q;
    end
  end
  for (genvar k = 0; k < N_CHANNELS; k++) begin : g_ch
    datapath_channel #(.W_IN(W_IN), .N_BITS_ACC_EXT(N_BITS_ACC_EXT)) u_ch (
      .clk(CLK_24M),
      .rst(reset),
      .tick(tick),
      .emit(tick_q),
      .diff_en(diff_en),
      .clear_sat(clear_sat),
      .counter_p(counter_p[k*W_IN +: W_IN]),
      .counter_n(counter_n[k*W_IN +: W_IN]),
      .channel_output(channel_output[k*W_IN +: W_IN]),
      .sat_flag(sat_flag[k])
    );
  end
endmodule

// File: tb/tb_datapath_multi_channel.sv
// tb_datapath_multi_channel: directed scoreboard bench for the multi-channel datapath
module tb_datapath_multi_channel;
  localparam int N = 4, W = 9, OW = N * W;
  logic clk = 1'b0, reset = 1'b1, diff_en = 1'b0, clear_sat = 1'b0, out_valid;
  logic [OW-1:0] counter_p = '0, counter_n = '0, channel_output, mask_all, mask_no2;
  logic [N-1:0] sat_flag;
  int cyc = 0, n_checks = 0, n_fail = 0;
  typedef struct {int cyc; logic [OW-1:0] data; logic [OW-1:0] mask; logic [N-1:0] sat;} exp_t;
  exp_t q[$];
  exp_t e;

  datapath_multi_channel dut (
    .CLK_24M(clk), .reset(reset), .counter_p(counter_p), .counter_n(counter_n),
    .diff_en(diff_en), .clear_sat(clear_sat), .channel_output(channel_output),
    .out_valid(out_valid), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;
  // cyc = number of edges since the last edge that saw reset
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  function automatic logic [OW-1:0] all(input int v);
    logic [OW-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = W'(v);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input int c, input int v, input logic [OW-1:0] m, input logic [N-1:0] s);
    q.push_back(exp_t'{c, all(v), m, s});
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input int p, input int n);
    counter_p[k*W +: W] = W'(p);
    counter_n[k*W +: W] = W'(n);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) step();
    check("queue_drained", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  task automatic goto(input int c);
    for (int i = 0; i < 2000 && cyc != c; i++) step();
    check("reach_cycle", 64'(cyc), 64'(c));
  endtask

  always @(negedge clk) begin
    if (out_valid && q.size() != 0) begin
      e = q.pop_front();
      if (e.cyc >= 0) check("strobe_cycle", 64'(cyc), 64'(e.cyc));
      check("channel_output", 64'(channel_output & e.mask), 64'(e.data & e.mask));
      check("sat_flag_at_strobe", 64'(sat_flag), 64'(e.sat));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mask_all = '1;
    mask_no2 = '1;
    mask_no2[2*W +: W] = '0;
    // reset with zero inputs, then strobes at edges 9, 17, 25
    step(2);
    check("reset_output", 64'(channel_output), 64'd0);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_sat", 64'(sat_flag), 64'd0);
    expect_out(9, 0, mask_all, 4'b0000);
    expect_out(17, 0, mask_all, 4'b0000);
    expect_out(25, 0, mask_all, 4'b0000);
    reset = 1'b0;
    drain(60);
    // constant +5 input settles to raw 5, difference 0
    counter_p = all(5);
    counter_n = '0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    goto(321);
    expect_out(-1, 5, mask_all, 4'b0000);
    expect_out(-1, 5, mask_all, 4'b0000);
    drain(40);
    diff_en = 1'b1;
    expect_out(-1, 0, mask_all, 4'b0000);
    expect_out(-1, 0, mask_all, 4'b0000);
    drain(40);
    // channel 2 clamps d; the other channels keep their value
    set_ch(2, 255, -256);
    diff_en = 1'b0;
    step();
    check("sat_ch2", 64'(sat_flag), 64'(4'b0100));
    expect_out(-1, 5, mask_no2, 4'b0100);
    expect_out(-1, 5, mask_no2, 4'b0100);
    drain(40);
    // clear and set on the same edge, then clear alone
    set_ch(2, 5, 0);
    step();
    clear_sat = 1'b1;
    set_ch(1, -256, 255);
    step();
    check("clear_with_set", 64'(sat_flag), 64'(4'b0010));
    set_ch(1, 5, 0);
    step();
    check("clear_alone", 64'(sat_flag), 64'd0);
    clear_sat = 1'b0;
    // reset pulse at cnt=5 discards the pending sample
    set_ch(3, 255, -256);
    step();
    check("pre_reset_sat", 64'(sat_flag), 64'(4'b1000));
    goto(cyc + ((13 - cyc % 8) % 8));
    reset = 1'b1;
    counter_p = all(5);
    counter_n = '0;
    step();
    reset = 1'b0;
    check("midreset_output", 64'(channel_output), 64'd0);
    check("midreset_valid", 64'(out_valid), 64'd0);
    check("midreset_sat", 64'(sat_flag), 64'd0);
    expect_out(9, 4, mask_all, 4'b0000);
    expect_out(17, 5, mask_all, 4'b0000);
    expect_out(25, 6, mask_all, 4'b0000);
    drain(60);
    // diff_en toggled at cnt=3 only takes effect at the next strobe
    goto(27);
    diff_en = 1'b1;
    step();
    check("hold_after_toggle", 64'(channel_output), 64'(all(6)));
    expect_out(33, -1, mask_all, 4'b0000);
    expect_out(41, 0, mask_all, 4'b0000);
    drain(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
